// File: rtl/fp_div_arbiter.sv
// Round-robin front end that time-shares one fp_div among N_REQ requesters:
// grant, launch, wait (with watchdog), then hand the quotient back to the owner.
module fp_div_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 63
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [32*N_REQ-1:0] op_a,
    input  logic [32*N_REQ-1:0] op_b,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    res_valid,
    input  logic [N_REQ-1:0]    res_ready,
    output logic [31:0]         res,
    output logic                busy,
    output logic                timeout_err,
    output logic                div_start,
    output logic [31:0]         div_op_a,
    output logic [31:0]         div_op_b,
    input  logic                div_done,
    input  logic [31:0]         div_res
);

    localparam int DATA_W = 32;
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id;
    logic [WD_W-1:0]   wdog;

    logic              found;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   scan_id;
    int                scan_idx;
    logic [DATA_W-1:0] a_arr [N_REQ];
    logic [DATA_W-1:0] b_arr [N_REQ];

    // Rotating search starting at the priority pointer; first set request wins.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_idx = 0;
        scan_id  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
            scan_id = ID_W'(scan_idx);
            if (!found && req[scan_id]) begin
                found = 1'b1;
                win   = scan_id;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            a_arr[i] = op_a[i*DATA_W +: DATA_W];
            b_arr[i] = op_b[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            res_valid   <= '0;
            div_start   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            res         <= '0;
            div_op_a    <= '0;
            div_op_b    <= '0;
            ptr         <= '0;
            id          <= '0;
            wdog        <= '0;
        end else begin
            gnt       <= '0;
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        id       <= win;
                        gnt[win] <= 1'b1;
                        div_op_a <= a_arr[win];
                        div_op_b <= b_arr[win];
                        busy     <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    div_start <= 1'b1;
                    wdog      <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // div_done is still high from idle while the start pulse is out.
                    if (div_done && !div_start) begin
                        res           <= div_res;
                        res_valid[id] <= 1'b1;
                        state         <= RESP;
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        timeout_err   <= 1'b1;
                        res           <= QNAN;
                        res_valid[id] <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    if (res_ready[id]) begin
                        res_valid <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                        if (id == ID_W'(N_REQ - 1)) ptr <= '0;
                        else                        ptr <= id + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp_div_arbiter.md
Name: fp_div_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one fp_div instance among N_REQ requesters.
- Accepts one request at a time, latches its operands, and pulses the divider start.
- Waits for completion, then returns the result to the owning requester with a valid/ready handshake.
- Includes a watchdog that flags a divider that never completes.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT, 63, maximum cycles allowed in WAIT before the error flag is raised.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  N_REQ  per-requester request, held high until gnt
- op_a  in  32*N_REQ  dividend per requester; slice i is [32*i+31:32*i]
- op_b  in  32*N_REQ  divisor per requester; same slicing
- gnt  out  N_REQ  one-hot, one-cycle acceptance pulse
- res_valid  out  N_REQ  one-hot result valid
- res_ready  in  N_REQ  per-requester result accept
- res  out  32  result data, shared bus, meaningful only when res_valid
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky watchdog flag
- div_start  out  1  divider start pulse
- div_op_a  out  32  divider dividend
- div_op_b  out  32  divider divisor
- div_done  in  1  divider done; also high while the divider is idle
- div_res  in  32  divider result

Behaviour:
- Reset (sync, rst=1 at posedge) values:
  - state=IDLE; gnt, res_valid, div_start, busy, timeout_err = 0.
  - res, div_op_a, div_op_b = 0.
  - priority pointer=0; watchdog counter=0.
  - Reset mid-operation abandons the transaction: no gnt repeat, no res_valid. The divider is left to finish on its own.
- Arbitration (IDLE):
  - Search order starts at the pointer and wraps modulo N_REQ; the first req bit set wins.
  - Winner id is latched; gnt[id]=1 for exactly one cycle; op_a/op_b slice id is latched into div_op_a/div_op_b; next state LAUNCH.
  - With no req, stay in IDLE.
- LAUNCH (1 cycle):
  - div_start=1; watchdog cleared; next state WAIT.
- WAIT:
  - div_done is ignored in the LAUNCH cycle, because it is still high from idle.
  - In WAIT, the first cycle with div_done=1 captures div_res into res; next state RESP.
  - Watchdog increments each WAIT cycle. On reaching TIMEOUT: timeout_err<=1 (sticky until rst), res<=32'h7FC00000 (quiet NaN), next state RESP.
- RESP:
  - res_valid[id]=1 and res is stable until res_ready[id]=1.
  - On handshake: res_valid drops next cycle, pointer<=(id+1) mod N_REQ, state IDLE.
  - res_ready of non-owners is ignored.
- Operand hold:
  - div_op_a/div_op_b stay constant from LAUNCH through the end of RESP, because the divider uses unregistered operands throughout the operation.
  - They change only on the next grant.
- Throughput and latency:
  - One outstanding operation at a time; no new grant while busy.
  - A request arriving in the RESP handshake cycle is granted at the earliest in the following IDLE cycle.
  - Latency from gnt to res_valid = 2 + D cycles, where D = cycles from the div_start edge to div_done high (D=53 for fp_div).
- Simultaneous events:
  - All req high in IDLE: the pointer holder wins.
  - req withdrawn before gnt: no grant occurs.
  - A requester asserting req again while its own result is pending is served only after RESP completes.

Test Plan:
- Single request, N_REQ=2, divider model with D=53: req[0], op_a=0x40C00000 (6.0), op_b=0x40000000 (2.0) -> gnt[0] for 1 cycle; div_start 1 cycle later; res_valid[0] 55 cycles after gnt; res=0x40400000 (3.0).
- Contention: req=2'b11 from reset -> requester 0 served first, then requester 1. Requester 1 uses 0x3F800000/0x40800000 and receives 0x3E800000 (0.25). Pointer then returns to 0; repeated contention alternates 0,1,0,1.
- Backpressure: hold res_ready[0]=0 for 10 cycles after res_valid -> res and res_valid stable; busy=1; req[1] not granted until the cycle after the handshake.
- Stale done: model keeps div_done=1 in the LAUNCH cycle and drops it the following cycle -> controller does not capture a result early; completes after D.
- Watchdog: model never raises div_done -> after 63 WAIT cycles timeout_err=1, res=0x7FC00000 delivered to the owner; timeout_err stays 1 through later normal operations until rst.
- Reset mid-WAIT: assert rst 20 cycles after div_start -> next cycle all outputs 0 and state IDLE; a new req[1] is granted normally afterwards.
